dispatch_queue: RTL and testbench

- N-wide circular instruction buffer between decode and the out-of-order core.
- Accepts decoded instruction bundles from decode and presents up to N oldest entries per cycle to the ooo dispatch input.
- Holds the whole bundle while ooo asserts structural_hazard.
- Flushes all contents when ooo asserts squash.

---
 rtl/dispatch_queue.sv | 110 +++++++++++
 tb/tb_dispatch_queue.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dispatch_queue.sv
// N-wide circular buffer between decode and out-of-order dispatch.
// Up to N oldest entries are offered per cycle. The whole bundle stalls on a structural hazard, and a squash empties the queue.

module dq_lane #(
  parameter int LANE  = 0,
  parameter int DEPTH = 8,
  parameter int PW    = 3,
  parameter int CW    = 4
) (
  input  logic [PW-1:0] head_i,
  input  logic [CW-1:0] avail_i,
  input  logic          stall_i,
  output logic          valid_o,
  output logic [PW-1:0] idx_o
);
  assign valid_o = (CW'(LANE) < avail_i) && !stall_i;
  assign idx_o   = PW'(head_i + PW'(LANE));
endmodule

module dispatch_queue #(
  parameter int N       = 2,
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 64,
  parameter int CNT_W   = 16,
  parameter int PW      = $clog2(DEPTH),
  parameter int CW      = $clog2(DEPTH+1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         in_valid,
  input  logic [N*ENTRY_W-1:0] in_entry,
  output logic                 in_ready,
  input  logic                 structural_hazard,
  input  logic                 squash,
  output logic [N-1:0]         out_valid,
  output logic [N*ENTRY_W-1:0] out_entry,
  output logic [CW-1:0]        count,
  output logic [CNT_W-1:0]     squash_count
);

  typedef struct packed {
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
  } ptr_t;

  ptr_t                            st_q, st_d;
  logic [CNT_W-1:0]                sqc_q, sqc_d;
  logic [DEPTH-1:0][ENTRY_W-1:0]   mem_q;
  logic [CW-1:0]                   enq_n, deq_n, avail;
  logic                            stall, run;
  logic [N-1:0][PW-1:0]            rd_idx;

  assign count        = st_q.count;
  assign squash_count = sqc_q;
  assign in_ready     = (CW'(DEPTH) - st_q.count) >= CW'(N);
  assign avail        = (st_q.count >= CW'(N)) ? CW'(N) : st_q.count;
  assign stall        = structural_hazard || squash;
  assign deq_n        = stall ? '0 : avail;

  // Only the leading run of valid slots is taken; anything after a hole is dropped.
  always_comb begin
    enq_n = '0;
    run   = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (run && in_valid[i]) enq_n = enq_n + CW'(1);
      else                    run   = 1'b0;
    end
    if (!in_ready || squash) enq_n = '0;
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    dq_lane #(.LANE(g), .DEPTH(DEPTH), .PW(PW), .CW(CW)) u_lane (
      .head_i  (st_q.head),
      .avail_i (avail),
      .stall_i (stall),
      .valid_o (out_valid[g]),
      .idx_o   (rd_idx[g])
    );
    assign out_entry[g*ENTRY_W +: ENTRY_W] = mem_q[rd_idx[g]];
  end

  always_comb begin
    st_d       = st_q;
    st_d.head  = PW'(st_q.head + PW'(deq_n));
    st_d.tail  = PW'(st_q.tail + PW'(enq_n));
    st_d.count = st_q.count + enq_n - deq_n;
    if (squash) st_d = '0;
    sqc_d = sqc_q;
    if (squash && (sqc_q != '1)) sqc_d = sqc_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q  <= '0;
      sqc_q <= '0;
    end else begin
      st_q  <= st_d;
      sqc_q <= sqc_d;
    end
  end

  // Storage is payload only and is left unreset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++)
      if (CW'(i) < enq_n)
        mem_q[PW'(st_q.tail + PW'(i))] <= in_entry[i*ENTRY_W +: ENTRY_W];
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: table of per-cycle vectors plus squash saturation and mid-run reset.

module tb_dispatch_queue;
  localparam int N = 2, DEPTH = 8, EW = 64, CNT_W = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    in_valid = '0;
  logic [N*EW-1:0] in_entry = '0;
  logic            in_ready;
  logic            structural_hazard = 1'b0;
  logic            squash = 1'b0;
  logic [N-1:0]    out_valid;
  logic [N*EW-1:0] out_entry;
  logic [3:0]      count;
  logic [CNT_W-1:0] squash_count;

  int tests = 0, fails = 0;

  always #5 clock = ~clock;

  dispatch_queue #(.N(N), .DEPTH(DEPTH), .ENTRY_W(EW), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_entry(in_entry),
    .in_ready(in_ready), .structural_hazard(structural_hazard), .squash(squash),
    .out_valid(out_valid), .out_entry(out_entry), .count(count),
    .squash_count(squash_count)
  );

  typedef struct {
    logic [1:0]  iv;
    logic [63:0] e0, e1;
    logic        hz, sq;
    logic [1:0]  ov, chk;
    logic [63:0] x0, x1;
    logic        rdy;
    int          cnt, sqc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] iv, int e0, int e1, logic hz, logic sq,
                              logic [1:0] ov, logic [1:0] chk, int x0, int x1,
                              logic rdy, int cnt, int sqc);
    vec_t v;
    v.iv = iv; v.e0 = 64'(e0); v.e1 = 64'(e1); v.hz = hz; v.sq = sq;
    v.ov = ov; v.chk = chk; v.x0 = 64'(x0); v.x1 = 64'(x1);
    v.rdy = rdy; v.cnt = cnt; v.sqc = sqc;
    return v;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(vec_t v, int idx);
    in_valid = v.iv; in_entry = {v.e1, v.e0};
    structural_hazard = v.hz; squash = v.sq;
    #1;
    chk($sformatf("v%0d out_valid", idx), longint'(out_valid), longint'(v.ov));
    chk($sformatf("v%0d in_ready", idx), longint'(in_ready), longint'(v.rdy));
    if (v.chk[0]) chk($sformatf("v%0d out_entry0", idx), longint'(out_entry[EW-1:0]), longint'(v.x0));
    if (v.chk[1]) chk($sformatf("v%0d out_entry1", idx), longint'(out_entry[2*EW-1:EW]), longint'(v.x1));
    @(posedge clock); #1;
    chk($sformatf("v%0d count", idx), longint'(count), longint'(v.cnt));
    chk($sformatf("v%0d squash_count", idx), longint'(squash_count), longint'(v.sqc));
    chk($sformatf("v%0d count_bound", idx), longint'(count <= 4'(DEPTH)), 1);
  endtask

  initial begin
    // fill under hazard, fifth bundle dropped
    tbl.push_back(mk(2'b11, 1, 2, 1, 0, 2'b00, 2'b00, 0, 0, 1, 2, 0));
    tbl.push_back(mk(2'b11, 3, 4, 1, 0, 2'b00, 2'b00, 0, 0, 1, 4, 0));
    tbl.push_back(mk(2'b11, 5, 6, 1, 0, 2'b00, 2'b00, 0, 0, 1, 6, 0));
    tbl.push_back(mk(2'b11, 7, 8, 1, 0, 2'b00, 2'b00, 0, 0, 1, 8, 0));
    tbl.push_back(mk(2'b11, 9, 10, 1, 0, 2'b00, 2'b11, 1, 2, 0, 8, 0));
    // drain
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 2'b11, 1, 2, 0, 6, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 2'b11, 3, 4, 1, 4, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 2'b11, 5, 6, 1, 2, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 2'b11, 7, 8, 1, 0, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0));
    // partial and non-contiguous valids
    tbl.push_back(mk(2'b01, 11, 12, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0));
    tbl.push_back(mk(2'b10, 13, 14, 1, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 2'b01, 2'b01, 11, 0, 1, 0, 0));
    // move head to 6
    tbl.push_back(mk(2'b11, 20, 21, 1, 0, 2'b00, 2'b00, 0, 0, 1, 2, 0));
    tbl.push_back(mk(2'b11, 22, 23, 1, 0, 2'b00, 2'b00, 0, 0, 1, 4, 0));
    tbl.push_back(mk(2'b01, 24, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 5, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 2'b11, 20, 21, 1, 3, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 2'b11, 22, 23, 1, 1, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 2'b01, 2'b01, 24, 0, 1, 0, 0));
    // count=3 at head=6, then steady enq/deq across the wrap
    tbl.push_back(mk(2'b11, 30, 31, 1, 0, 2'b00, 2'b00, 0, 0, 1, 2, 0));
    tbl.push_back(mk(2'b01, 32, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 3, 0));
    for (int k = 1; k <= 6; k++)
      tbl.push_back(mk(2'b11, 31+2*k, 32+2*k, 0, 0, 2'b11, 2'b11, 28+2*k, 29+2*k, 1, 3, 0));
    // hazard toggling with count=4
    tbl.push_back(mk(2'b01, 45, 0, 1, 0, 2'b00, 2'b11, 42, 43, 1, 4, 0));
    tbl.push_back(mk(2'b00, 0, 0, 1, 0, 2'b00, 2'b11, 42, 43, 1, 4, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 2'b11, 42, 43, 1, 2, 0));
    tbl.push_back(mk(2'b00, 0, 0, 1, 0, 2'b00, 2'b11, 44, 45, 1, 2, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 2'b11, 44, 45, 1, 0, 0));
    // squash priority and hold
    tbl.push_back(mk(2'b11, 50, 51, 1, 0, 2'b00, 2'b00, 0, 0, 1, 2, 0));
    tbl.push_back(mk(2'b11, 52, 53, 1, 0, 2'b00, 2'b00, 0, 0, 1, 4, 0));
    tbl.push_back(mk(2'b11, 99, 98, 0, 1, 2'b00, 2'b00, 0, 0, 1, 0, 1));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 0, 2));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 0, 3));
    tbl.push_back(mk(2'b11, 60, 61, 1, 0, 2'b00, 2'b00, 0, 0, 1, 2, 3));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 2'b11, 60, 61, 1, 0, 3));

    #2;
    chk("reset count", longint'(count), 0);
    chk("reset out_valid", longint'(out_valid), 0);
    chk("reset in_ready", longint'(in_ready), 1);
    chk("reset squash_count", longint'(squash_count), 0);
    #10 reset = 1'b1;
    @(posedge clock); #1;

    foreach (tbl[i]) step(tbl[i], i);

    // squash_count saturates at all-ones
    for (int k = 1; k <= 6; k++) begin
      in_valid = '0; structural_hazard = 1'b0; squash = 1'b1;
      @(posedge clock); #1;
      chk($sformatf("sat squash_count k%0d", k), longint'(squash_count),
          (3 + k > 7) ? 7 : 3 + k);
    end
    squash = 1'b0;

    // mid-run asynchronous reset with count=5
    step(mk(2'b11, 70, 71, 1, 0, 2'b00, 2'b00, 0, 0, 1, 2, 7), 100);
    step(mk(2'b11, 72, 73, 1, 0, 2'b00, 2'b00, 0, 0, 1, 4, 7), 101);
    step(mk(2'b01, 74, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 5, 7), 102);
    structural_hazard = 1'b0; in_valid = '0;
    #2 reset = 1'b0;
    #1;
    chk("midreset count", longint'(count), 0);
    chk("midreset out_valid", longint'(out_valid), 0);
    chk("midreset in_ready", longint'(in_ready), 1);
    chk("midreset squash_count", longint'(squash_count), 0);
    #13 reset = 1'b1;
    @(posedge clock); #1;
    chk("post-reset squash_count", longint'(squash_count), 0);
    chk("post-reset count", longint'(count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
